// File: rtl/csa_accumulator.sv
// csa_accumulator: sums NUM_OPS 16-bit operands per burst through a square-root
// carry-select adder, counts adder carry-outs and hands the result over a
// valid/ready port.
// Optional build macro: CSA_ACC_SAT_EN -- a carry-out pins the accumulator at
// 16'hFFFF for the rest of the burst instead of wrapping.
// The adder submodule csa is kept in this file so the block is self-contained.

// 16-bit square-root carry-select adder, blocks of 2,2,3,4,5 bits.
module csa (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        carry_in,
  output logic [15:0] sum,
  output logic        carry_out
);

  localparam int unsigned NumBlk = 5;

  function automatic int unsigned blk_lo(input int unsigned k);
    case (k)
      0:       return 0;
      1:       return 2;
      2:       return 4;
      3:       return 7;
      default: return 11;
    endcase
  endfunction

  function automatic int unsigned blk_hi(input int unsigned k);
    case (k)
      0:       return 1;
      1:       return 3;
      2:       return 6;
      3:       return 10;
      default: return 15;
    endcase
  endfunction

  logic [15:0] s0, s1;
  logic        r0, r1, c;

  // Each block precomputes both carry-in cases; the incoming carry only selects.
  always_comb begin
    sum = '0;
    s0  = '0;
    s1  = '0;
    r0  = 1'b0;
    r1  = 1'b1;
    c   = carry_in;
    for (int unsigned k = 0; k < NumBlk; k++) begin
      r0 = 1'b0;
      r1 = 1'b1;
      for (int unsigned i = 0; i < 16; i++) begin
        if (i >= blk_lo(k) && i <= blk_hi(k)) begin
          s0[i] = a[i] ^ b[i] ^ r0;
          r0    = (a[i] & b[i]) | (r0 & (a[i] ^ b[i]));
          s1[i] = a[i] ^ b[i] ^ r1;
          r1    = (a[i] & b[i]) | (r1 & (a[i] ^ b[i]));
        end
      end
      for (int unsigned i = 0; i < 16; i++) begin
        if (i >= blk_lo(k) && i <= blk_hi(k)) begin
          sum[i] = c ? s1[i] : s0[i];
        end
      end
      c = c ? r1 : r0;
    end
    carry_out = c;
  end

endmodule

module csa_accumulator #(
  parameter int unsigned NUM_OPS = 4,
  parameter int unsigned CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_sum,
  output logic [CNT_W-1:0] out_carries,
  output logic             out_ovf
);

  typedef enum logic [1:0] {StIdle, StAcc, StDone} state_e;

  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(NUM_OPS - 1);

  state_e           state;
  logic [15:0]      acc;
  logic [15:0]      acc_next;
  logic [CNT_W-1:0] op_cnt;
  logic [CNT_W-1:0] carry_cnt;
  logic [CNT_W-1:0] carry_cnt_inc;
  logic             ovf;
  logic             ready_q;
  logic [15:0]      add_a;
  logic [15:0]      add_sum;
  logic             add_co;
  logic             accept;

  // First add of a burst starts from zero so a stale acc never leaks in.
  assign add_a = (state == StIdle) ? 16'h0000 : acc;

  csa u_csa (
    .a         (add_a),
    .b         (in_data),
    .carry_in  (1'b0),
    .sum       (add_sum),
    .carry_out (add_co)
  );

  // ready_q is the registered state decode; rst gates it so nothing is taken in reset.
  assign in_ready      = ready_q & ~rst;
  assign accept        = in_valid & in_ready;
  assign carry_cnt_inc = (carry_cnt == '1) ? carry_cnt : carry_cnt + 1'b1;

  assign out_sum     = acc;
  assign out_carries = carry_cnt;
  assign out_ovf     = ovf;

`ifdef CSA_ACC_SAT_EN
  logic sat;

  // Once any add has carried, the burst result is pinned at full scale.
  always_comb begin
    acc_next = add_sum;
    if (sat || add_co) begin
      acc_next = 16'hFFFF;
    end
  end
`else
  assign acc_next = add_sum;
`endif

  // Burst FSM plus datapath registers; all outputs come from flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= StIdle;
      acc       <= 16'h0000;
      op_cnt    <= '0;
      carry_cnt <= '0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
      ready_q   <= 1'b1;
`ifdef CSA_ACC_SAT_EN
      sat       <= 1'b0;
`endif
    end else begin
      unique case (state)
        StIdle: begin
          if (accept) begin
            acc       <= add_sum;
            op_cnt    <= CNT_W'(1);
            carry_cnt <= '0;
            ovf       <= 1'b0;
`ifdef CSA_ACC_SAT_EN
            sat       <= 1'b0;
`endif
            state     <= StAcc;
          end
        end
        StAcc: begin
          if (accept) begin
            acc    <= acc_next;
            op_cnt <= op_cnt + 1'b1;
            if (add_co) begin
              carry_cnt <= carry_cnt_inc;
              ovf       <= 1'b1;
`ifdef CSA_ACC_SAT_EN
              sat       <= 1'b1;
`endif
            end
            if (op_cnt == LastCnt) begin
              state     <= StDone;
              out_valid <= 1'b1;
              ready_q   <= 1'b0;
            end
          end
        end
        StDone: begin
          if (out_ready) begin
            state     <= StIdle;
            out_valid <= 1'b0;
            ready_q   <= 1'b1;
`ifdef CSA_ACC_SAT_EN
            sat       <= 1'b0;
`endif
          end
        end
        default: begin
          state     <= StIdle;
          out_valid <= 1'b0;
          ready_q   <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_csa_accumulator.sv
// Bench for csa_accumulator: a burst-level arithmetic model checked every cycle,
// plus directed bursts with hand-computed results.
module tb_csa_accumulator;

  localparam int unsigned NUM_OPS = 4;
  localparam int unsigned CNT_W   = 8;
  localparam int unsigned CntMax  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [15:0]      in_data = 16'h0000;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [15:0]      out_sum;
  logic [CNT_W-1:0] out_carries;
  logic             out_ovf;

  int n_cmp = 0;
  int n_err = 0;

  csa_accumulator #(
    .NUM_OPS (NUM_OPS),
    .CNT_W   (CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_sum     (out_sum),
    .out_carries (out_carries),
    .out_ovf     (out_ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Burst model: integer sum of operands, carry when it crosses 2^16.
  bit          started = 1'b0;
  bit          m_done  = 1'b0;
  int unsigned m_cnt   = 0;
  int unsigned m_sum   = 0;
  int unsigned m_car   = 0;
  bit          m_ovf   = 1'b0;
  bit          m_sat   = 1'b0;
  logic        exp_in_ready;

  assign exp_in_ready = !rst && !m_done;

  always @(posedge clk) begin
    int unsigned t;
    started <= 1'b1;
    if (rst) begin
      m_done = 1'b0;
      m_cnt  = 0;
      m_sum  = 0;
      m_car  = 0;
      m_ovf  = 1'b0;
      m_sat  = 1'b0;
    end else if (m_done) begin
      if (out_ready) m_done = 1'b0;
    end else if (in_valid) begin
      if (m_cnt == 0) begin
        m_sum = 0;
        m_car = 0;
        m_ovf = 1'b0;
        m_sat = 1'b0;
      end
      t     = m_sum + in_data;
      m_sum = t % 65536;
      if (t >= 65536) begin
        if (m_car < CntMax) m_car++;
        m_ovf = 1'b1;
        m_sat = 1'b1;
      end
`ifdef CSA_ACC_SAT_EN
      if (m_sat) m_sum = 16'hFFFF;
`endif
      m_cnt++;
      if (m_cnt == NUM_OPS) begin
        m_done = 1'b1;
        m_cnt  = 0;
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (started) begin
      chk("in_ready", 32'(in_ready), 32'(exp_in_ready));
      chk("out_valid", 32'(out_valid), 32'(m_done));
      if (m_done && !rst) begin
        chk("model out_sum", 32'(out_sum), m_sum);
        chk("model out_carries", 32'(out_carries), m_car);
        chk("model out_ovf", 32'(out_ovf), 32'(m_ovf));
      end
    end
  end

  task automatic send(input logic [15:0] d);
    bit ok = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      ok = exp_in_ready;
      @(posedge clk);
      #2;
      if (ok) break;
    end
    in_valid = 1'b0;
    if (!ok) chk("send timeout", 32'(0), 32'(1));
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic wait_valid();
    bit seen = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (out_valid === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) chk("out_valid timeout", 32'(0), 32'(1));
  endtask

  task automatic take_result();
    out_ready = 1'b1;
    @(posedge clk);
    #2;
    out_ready = 1'b0;
  endtask

  initial begin
    // Reset
    idle(2);
    @(negedge clk);
    chk("reset in_ready", 32'(in_ready), 32'(0));
    chk("reset out_valid", 32'(out_valid), 32'(0));
    @(posedge clk);
    #2;
    rst = 1'b0;
    @(negedge clk);
    chk("post-reset in_ready", 32'(in_ready), 32'(1));
    @(posedge clk);
    #2;

    // 1+2+3+4, consumer always ready
    out_ready = 1'b1;
    send(16'h0001);
    send(16'h0002);
    send(16'h0003);
    send(16'h0004);
    @(negedge clk);
    chk("latency out_valid", 32'(out_valid), 32'(1));
    chk("simple out_sum", 32'(out_sum), 32'h000A);
    chk("simple out_carries", 32'(out_carries), 32'(0));
    chk("simple out_ovf", 32'(out_ovf), 32'(0));
    @(negedge clk);
    chk("after handshake in_ready", 32'(in_ready), 32'(1));
    chk("after handshake out_valid", 32'(out_valid), 32'(0));
    out_ready = 1'b0;
    idle(1);

    // FFFF+1 carries to 0, 0+8000+8000 carries to 0
    send(16'hFFFF);
    send(16'h0001);
    send(16'h8000);
    send(16'h8000);
    wait_valid();
`ifdef CSA_ACC_SAT_EN
    chk("carry out_sum", 32'(out_sum), 32'hFFFF);
`else
    chk("carry out_sum", 32'(out_sum), 32'h0000);
    chk("carry out_carries", 32'(out_carries), 32'(2));
`endif
    chk("carry out_ovf", 32'(out_ovf), 32'(1));
    take_result();

    // Backpressure: result held, pending operand not consumed
    send(16'h0001);
    send(16'h0002);
    send(16'h0003);
    send(16'h0004);
    in_valid = 1'b1;
    in_data  = 16'h1234;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp out_valid", 32'(out_valid), 32'(1));
      chk("bp in_ready", 32'(in_ready), 32'(0));
      chk("bp out_sum", 32'(out_sum), 32'h000A);
      @(posedge clk);
      #2;
    end
    take_result();
    send(16'h1234);
    send(16'h0000);
    send(16'h0000);
    send(16'h0000);
    wait_valid();
    chk("bp next out_sum", 32'(out_sum), 32'h1234);
    take_result();

    // Gapped: 7FFF+1=8000, +00FF=80FF, +FF01=1_8000 -> 8000 with one carry
    send(16'h7FFF);
    idle(2);
    send(16'h0001);
    idle(2);
    send(16'h00FF);
    idle(2);
    send(16'hFF01);
    wait_valid();
`ifdef CSA_ACC_SAT_EN
    chk("gap out_sum", 32'(out_sum), 32'hFFFF);
`else
    chk("gap out_sum", 32'(out_sum), 32'h8000);
`endif
    chk("gap out_carries", 32'(out_carries), 32'(1));
    take_result();

    // Reset mid-burst discards the partial sum
    send(16'h1111);
    send(16'h2222);
    rst = 1'b1;
    @(negedge clk);
    chk("mid-reset in_ready", 32'(in_ready), 32'(0));
    chk("mid-reset out_valid", 32'(out_valid), 32'(0));
    @(posedge clk);
    #2;
    rst = 1'b0;
    send(16'h0001);
    send(16'h0001);
    send(16'h0001);
    send(16'h0001);
    wait_valid();
    chk("after reset out_sum", 32'(out_sum), 32'h0004);
    chk("after reset out_carries", 32'(out_carries), 32'(0));
    take_result();

    // Random traffic, checked by the model every cycle
    for (int k = 0; k < 4000; k++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_data   = 16'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk);
      #2;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    idle(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
